multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 49 ++++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared MIPS multicycle control definitions: state encoding, opcodes and datapath select codes.
// Also used by the ALU control block, so the codes here must stay stable.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StAddiExec = 4'd10,
    StAddiWb   = 4'd11
  } state_e;

  // Instruction opcodes, bits [31:26]
  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  // ALU operation class handed to the ALU control block
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  function automatic logic op_supported(logic [5:0] op, logic addi_en);
    return (op inside {OpRType, OpLw, OpSw, OpBeq, OpBne, OpJ}) || (addi_en && op == OpAddi);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM. Outputs decode from the registered state; only the memory
// handshake and the DECODE opcode dispatch look at live inputs.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          ADDI_EN       = 1'b1,
  parameter int unsigned ALUOP_W       = 2     // must be at least 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_beq,
  output logic               pc_write_bne,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state_dbg
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [1:0] alu_op_base;
  logic       mem_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      op_q    <= OpRType;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Without the handshake every memory access is treated as finishing in its first cycle.
  assign mem_go = mem_ready || !MEM_HANDSHAKE;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    pc_write     = 1'b0;
    pc_write_beq = 1'b0;
    pc_write_bne = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_dst      = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SrcBReg;
    alu_op_base  = AluOpAdd;
    pc_source    = PcSrcAlu;
    instr_done   = 1'b0;
    illegal_op   = 1'b0;

    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = SrcBFour;
        ir_write  = mem_go;
        pc_write  = mem_go;
        if (mem_go) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = SrcBImmSh;
        op_d      = opcode;
        if (!op_supported(opcode, ADDI_EN)) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
          state_d    = StFetch;
        end else begin
          case (opcode)
            OpRType:     state_d = StRExec;
            OpLw, OpSw:  state_d = StMemAddr;
            OpBeq, OpBne: state_d = StBranch;
            OpJ:         state_d = StJump;
            default:     state_d = StAddiExec;
          endcase
        end
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = (op_q == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_go) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_go;
        if (mem_go) state_d = StFetch;
      end
      StRExec: begin
        alu_src_a   = 1'b1;
        alu_op_base = AluOpFunct;
        state_d     = StRWb;
      end
      StRWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StBranch: begin
        alu_src_a    = 1'b1;
        alu_op_base  = AluOpSub;
        pc_source    = PcSrcAluOut;
        pc_write_beq = (op_q == OpBeq);
        pc_write_bne = (op_q == OpBne);
        instr_done   = 1'b1;
        state_d      = StFetch;
      end
      StJump: begin
        pc_write   = 1'b1;
        pc_source  = PcSrcJump;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign alu_op    = ALUOP_W'(alu_op_base);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed literal checks plus a randomized run compared every
// cycle against an instruction-sequence model, on a default instance and a no-handshake one.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;

  always #5 clk = ~clk;

  // Phase codes as the state_dbg values listed in state order
  localparam logic [3:0] PF = 4'd0, PD = 4'd1, PMA = 4'd2, PMR = 4'd3, PMWB = 4'd4, PMW = 4'd5;
  localparam logic [3:0] PRE = 4'd6, PRW = 4'd7, PBR = 4'd8, PJ = 4'd9, PAE = 4'd10, PAW = 4'd11;

  typedef struct packed {
    logic       pcw, beq, bne, iord, mr, mw, irw, rdst, rw, m2r, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] pcs;
    logic       done, ill;
    logic [3:0] st;
  } outs_t;

  typedef struct packed {
    int              n;
    logic [3:0][3:0] ph;
  } plan_t;

  logic       pcw_a, beq_a, bne_a, iord_a, mr_a, mw_a, irw_a, rdst_a, rw_a, m2r_a, asa_a;
  logic       done_a, ill_a;
  logic [1:0] asb_a, aop_a, pcs_a;
  logic [3:0] st_a;
  logic       pcw_b, beq_b, bne_b, iord_b, mr_b, mw_b, irw_b, rdst_b, rw_b, m2r_b, asa_b;
  logic       done_b, ill_b;
  logic [1:0] asb_b, pcs_b;
  logic [2:0] aop_b;
  logic [3:0] st_b;

  multicycle_control #(.MEM_HANDSHAKE(1'b1), .ADDI_EN(1'b1), .ALUOP_W(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_a), .pc_write_beq(beq_a), .pc_write_bne(bne_a), .iord(iord_a),
    .mem_read(mr_a), .mem_write(mw_a), .ir_write(irw_a), .reg_dst(rdst_a),
    .reg_write(rw_a), .mem_to_reg(m2r_a), .alu_src_a(asa_a), .alu_src_b(asb_a),
    .alu_op(aop_a), .pc_source(pcs_a), .instr_done(done_a), .illegal_op(ill_a),
    .state_dbg(st_a)
  );

  multicycle_control #(.MEM_HANDSHAKE(1'b0), .ADDI_EN(1'b0), .ALUOP_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw_b), .pc_write_beq(beq_b), .pc_write_bne(bne_b), .iord(iord_b),
    .mem_read(mr_b), .mem_write(mw_b), .ir_write(irw_b), .reg_dst(rdst_b),
    .reg_write(rw_b), .mem_to_reg(m2r_b), .alu_src_a(asa_b), .alu_src_b(asb_b),
    .alu_op(aop_b), .pc_source(pcs_b), .instr_done(done_b), .illegal_op(ill_b),
    .state_dbg(st_b)
  );

  outs_t out_a, out_b;
  assign out_a = {pcw_a, beq_a, bne_a, iord_a, mr_a, mw_a, irw_a, rdst_a, rw_a, m2r_a, asa_a,
                  asb_a, 1'b0, aop_a, pcs_a, done_a, ill_a, st_a};
  assign out_b = {pcw_b, beq_b, bne_b, iord_b, mr_b, mw_b, irw_b, rdst_b, rw_b, m2r_b, asa_b,
                  asb_b, aop_b, pcs_b, done_b, ill_b, st_b};

  int n_cmp = 0;
  int n_fail = 0;

  function automatic bit legal(logic [5:0] op, bit ae);
    return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 || op == 6'h05 ||
           op == 6'h02 || (ae && op == 6'h08);
  endfunction

  // Phases that follow DECODE for a given instruction
  function automatic plan_t make_plan(logic [5:0] op, bit ae);
    plan_t p;
    p = '0;
    case (op)
      6'h00: begin p.n = 2; p.ph[0] = PRE; p.ph[1] = PRW; end
      6'h23: begin p.n = 3; p.ph[0] = PMA; p.ph[1] = PMR; p.ph[2] = PMWB; end
      6'h2b: begin p.n = 2; p.ph[0] = PMA; p.ph[1] = PMW; end
      6'h04, 6'h05: begin p.n = 1; p.ph[0] = PBR; end
      6'h02: begin p.n = 1; p.ph[0] = PJ; end
      6'h08: if (ae) begin p.n = 2; p.ph[0] = PAE; p.ph[1] = PAW; end
      default: p.n = 0;
    endcase
    return p;
  endfunction

  function automatic outs_t expect_out(logic [3:0] ph, logic [5:0] lop, logic [5:0] op,
                                       logic rdy, bit hs, bit ae);
    outs_t o;
    bit    g;
    o    = '0;
    g    = rdy || !hs;
    o.st = ph;
    case (ph)
      PF:   begin o.mr = 1; o.asb = 2'b01; o.irw = g; o.pcw = g; end
      PD:   begin o.asb = 2'b11; o.ill = !legal(op, ae); o.done = !legal(op, ae); end
      PMA:  begin o.asa = 1; o.asb = 2'b10; end
      PMR:  begin o.mr = 1; o.iord = 1; end
      PMWB: begin o.rw = 1; o.m2r = 1; o.done = 1; end
      PMW:  begin o.mw = 1; o.iord = 1; o.done = g; end
      PRE:  begin o.asa = 1; o.aop = 3'b010; end
      PRW:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
      PBR:  begin
        o.asa = 1; o.aop = 3'b001; o.pcs = 2'b01; o.done = 1;
        o.beq = (lop == 6'h04); o.bne = (lop == 6'h05);
      end
      PJ:   begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
      PAE:  begin o.asa = 1; o.asb = 2'b10; end
      PAW:  begin o.rw = 1; o.done = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  logic [3:0] ph[2] = '{PF, PF};
  logic [5:0] lop[2] = '{6'd0, 6'd0};
  plan_t      plan[2];
  int         pidx[2] = '{0, 0};

  function automatic logic [3:0] pop_plan(int k);
    logic [3:0] r;
    if (pidx[k] < plan[k].n) begin
      r = plan[k].ph[pidx[k]];
      pidx[k]++;
    end else begin
      r = PF;
    end
    return r;
  endfunction

  bit    hs, ae, go;
  outs_t exp_o, got_o;

  // Model compare: every falling edge, then advance the model to the next cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      hs = (k == 0);
      ae = (k == 0);
      if (!rst_n) begin ph[k] = PF; lop[k] = 6'd0; end
      exp_o = expect_out(ph[k], lop[k], opcode, mem_ready, hs, ae);
      got_o = (k == 0) ? out_a : out_b;
      n_cmp++;
      if (got_o !== exp_o) begin
        n_fail++;
        $display("FAIL model dut_%s t=%0t: got %h expected %h", (k == 0) ? "a" : "b", $time,
                 got_o, exp_o);
      end
      if (rst_n) begin
        go = mem_ready || !hs;
        case (ph[k])
          PF: if (go) ph[k] = PD;
          PD: begin
            lop[k]  = opcode;
            plan[k] = make_plan(opcode, ae);
            pidx[k] = 0;
            ph[k]   = pop_plan(k);
          end
          PMR, PMW: if (go) ph[k] = pop_plan(k);
          default: ph[k] = pop_plan(k);
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] op, input logic rdy);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask

  int         lw_seq[5] = '{0, 1, 2, 3, 4};
  int         r_seq[4] = '{0, 1, 6, 7};
  int         dcnt, mwcnt;
  logic [5:0] ops[9] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h08, 6'h3f, 6'h11};

  initial begin
    // Reset: FETCH decode visible while held
    repeat (2) @(posedge clk);
    #1;
    chk("reset state_dbg", st_a, 0);
    chk("reset mem_read", mr_a, 1);
    chk("reset ir_write stalled", irw_a, 0);
    chk("reset reg_write", rw_a, 0);
    chk("reset ir_write no-handshake", irw_b, 1);

    // lw with mem_ready high: five cycles, one done
    rst_n = 1'b1; opcode = 6'h23; mem_ready = 1'b1;
    #1;
    chk("first fetch mem_read", mr_a, 1);
    chk("first fetch ir_write", irw_a, 1);
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) step(6'h23, 1'b1);
      chk($sformatf("lw state c%0d", c), st_a, lw_seq[c]);
      chk($sformatf("lw reg_write+mem_to_reg c%0d", c), {rw_a, m2r_a}, (c == 4) ? 2 'b11 : 2'b00);
      dcnt += int'(done_a);
    end
    chk("lw instr_done count", dcnt, 1);

    // sw with three stalled MEM_WR cycles
    step(6'h2b, 1'b1);
    chk("sw fetch", st_a, 0);
    step(6'h2b, 1'b1);
    step(6'h2b, 1'b0);
    chk("sw mem_addr", st_a, 2);
    mwcnt = 0;
    for (int c = 0; c < 4; c++) begin
      step(6'h2b, c == 3);
      mwcnt += int'(mw_a);
      chk($sformatf("sw instr_done c%0d", c), done_a, (c == 3));
    end
    chk("sw mem_write cycles", mwcnt, 4);
    step(6'h04, 1'b1);
    chk("sw back to fetch", {st_a, mw_a}, 0);

    // beq then bne
    step(6'h04, 1'b1);
    step(6'h04, 1'b1);
    chk("beq pc_write_beq/bne", {beq_a, bne_a}, 2'b10);
    chk("beq pc_source", pcs_a, 2'b01);
    step(6'h05, 1'b1);
    step(6'h05, 1'b1);
    step(6'h05, 1'b1);
    chk("bne pc_write_beq/bne", {beq_a, bne_a}, 2'b01);
    chk("bne pc_source", pcs_a, 2'b01);

    // Illegal opcode
    step(6'h3f, 1'b1);
    step(6'h3f, 1'b1);
    chk("illegal decode pulses", {st_a, ill_a, done_a}, {4'd1, 2'b11});
    step(6'h23, 1'b1);
    chk("illegal returns to fetch", {st_a, ill_a}, 0);

    // Reset while waiting in MEM_RD
    step(6'h23, 1'b0);
    step(6'h23, 1'b0);
    step(6'h23, 1'b0);
    step(6'h23, 1'b0);
    chk("lw waiting in mem_rd", st_a, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset state", {st_a, rw_a, done_a}, 0);
    @(posedge clk);
    #1;
    chk("held reset no done", {st_a, rw_a, done_a}, 0);

    // No-handshake / no-addi instance
    rst_n = 1'b1; opcode = 6'h08; mem_ready = 1'b0;
    #1;
    chk("b fetch ir_write without ready", {st_b, irw_b, pcw_b}, 6'b0000_11);
    chk("a fetch stalled", {irw_a, pcw_a}, 0);
    step(6'h08, 1'b0);
    chk("b addi disabled is illegal", {st_b, ill_b, done_b}, {4'd1, 2'b11});
    chk("a still in fetch", st_a, 0);
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      step(6'h00, 1'b0);
      chk($sformatf("b rtype state c%0d", c), st_b, r_seq[c]);
      if (c == 2) chk("b rtype alu_op", aop_b, 3'b010);
      if (c == 3) chk("b rtype writeback", {rw_b, rdst_b, m2r_b}, 3'b110);
      dcnt += int'(done_b);
    end
    chk("b rtype instr_done count", dcnt, 1);
    step(6'h00, 1'b0);
    chk("b rtype back to fetch", st_b, 0);

    // Randomized run, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst_n     = ($urandom_range(0, 99) != 0);
      opcode    = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      mem_ready = ($urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
